// File: rtl/mux_key_with_default_pkg.sv
// Shared packing convention for key/data lookup tables.
// Entry i of a table lives at bits [i*PAIR +: PAIR]; inside an entry the
// key occupies the upper KEY_LEN bits and the data the lower DATA_LEN bits,
// so entry 0 is the rightmost pair of a {k_{N-1},d_{N-1},...,k_0,d_0}
// concatenation. Every instantiator packs its table through these helpers.
package mux_key_with_default_pkg;

  // Width of one (key, data) pair.
  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

  // Total width of a table holding nr_key pairs.
  function automatic int lut_len(input int nr_key, input int key_len, input int data_len);
    return nr_key * pair_len(key_len, data_len);
  endfunction

  // Bit offset of the data field of entry idx.
  function automatic int data_lsb(input int idx, input int key_len, input int data_len);
    return idx * pair_len(key_len, data_len);
  endfunction

  // Bit offset of the key field of entry idx; the key sits above the data.
  function automatic int key_lsb(input int idx, input int key_len, input int data_len);
    return idx * pair_len(key_len, data_len) + data_len;
  endfunction

endpackage

// File: rtl/mux_key_with_default_core.sv
// Combinational core of the key lookup: per-entry equality match followed
// by a priority select in which the lowest-index matching entry wins.
// Duplicate keys therefore never OR their data together.
module mux_key_core
  import mux_key_with_default_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                         key,
  input  logic [DATA_LEN-1:0]                        default_out,
  input  logic [lut_len(NR_KEY, KEY_LEN, DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                        out,
  output logic                                       hit
);

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] entry_data [NR_KEY];

  for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
    assign match[i]      = (lut[key_lsb(i, KEY_LEN, DATA_LEN) +: KEY_LEN] == key);
    assign entry_data[i] = lut[data_lsb(i, KEY_LEN, DATA_LEN) +: DATA_LEN];
  end

  assign hit = |match;

  // Walk entries from highest to lowest index so the lowest matching index is the last writer.
  always_comb begin
    out = default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) begin
        out = entry_data[i];
      end
    end
  end

endmodule

// File: rtl/mux_key_with_default.sv
// Key lookup multiplexer with default value. The combinational result and
// hit flag serve same-cycle datapaths; out_q/hit_q are one-cycle registered
// copies for pipelined consumers, cleared by a synchronous active-low reset.
module mux_key_with_default
  import mux_key_with_default_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [KEY_LEN-1:0]                         key,
  input  logic [DATA_LEN-1:0]                        default_out,
  input  logic [lut_len(NR_KEY, KEY_LEN, DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                        out,
  output logic                                       hit,
  output logic [DATA_LEN-1:0]                        out_q,
  output logic                                       hit_q
);

  mux_key_core #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_core (
    .key        (key),
    .default_out(default_out),
    .lut        (lut),
    .out        (out),
    .hit        (hit)
  );

  // Register the live lookup each cycle; reset clears both copies and wins over any input change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key_with_default.sv
// Self-checking bench for mux_key_with_default: a 4-entry CSR-style table
// (12-bit keys, 32-bit data) plus a 1/1/1 edge-parameter instance.
// Registered expectations are queued when stimulus is applied and popped
// one edge later.
module tb_mux_key_with_default;

  localparam int LUT_W = 4 * (12 + 32);

  logic              clk;
  logic              rst;
  logic [11:0]       key;
  logic [31:0]       default_out;
  logic [LUT_W-1:0]  lut;
  logic [31:0]       out, out_q;
  logic              hit, hit_q;

  logic              e_key, e_def, e_out, e_hit, e_out_q, e_hit_q;
  logic [1:0]        e_lut;

  int check_count;
  int pass_count;

  logic [31:0] sb_data [$];
  logic        sb_hit  [$];

  localparam logic [LUT_W-1:0] CSR_LUT = {12'h300, 32'h0000_1800,
                                          12'h305, 32'h8000_0000,
                                          12'h341, 32'h1234_5678,
                                          12'h342, 32'h0000_000B};

  localparam logic [LUT_W-1:0] DUP_LUT = {12'h300, 32'h0000_1800,
                                          12'h341, 32'h0000_0002,
                                          12'h305, 32'h0000_0000,
                                          12'h341, 32'h0000_0001};

  mux_key_with_default #(.NR_KEY(4), .KEY_LEN(12), .DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .key(key), .default_out(default_out), .lut(lut),
    .out(out), .hit(hit), .out_q(out_q), .hit_q(hit_q)
  );

  mux_key_with_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) dut_edge (
    .clk(clk), .rst(rst), .key(e_key), .default_out(e_def), .lut(e_lut),
    .out(e_out), .hit(e_hit), .out_q(e_out_q), .hit_q(e_hit_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference lookup: first matching entry scanning upward from entry 0.
  function automatic logic [32:0] ref_lookup(input logic [11:0] k, input logic [LUT_W-1:0] t,
                                             input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (t[i*44 + 32 +: 12] == k) return {1'b1, t[i*44 +: 32]};
    end
    return {1'b0, d};
  endfunction

  // Apply inputs after a falling edge and queue what the registers must hold after the next rising edge.
  task automatic drive(input logic [11:0] k, input logic [LUT_W-1:0] t, input logic [31:0] d,
                       input logic r);
    logic [32:0] exp;
    @(negedge clk);
    key = k; lut = t; default_out = d; rst = r;
    #1;
    exp = ref_lookup(k, t, d);
    sb_data.push_back(r ? exp[31:0] : 32'h0);
    sb_hit.push_back(r ? exp[32] : 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] ed;
    logic        eh;
    for (int n = 0; n < 2; n++) begin
      drive(12'h305, CSR_LUT, 32'h0, 1'b0);
      e_key = 1'b1; e_lut = 2'b11; e_def = 1'b0;
      check_count++;
      if (out !== 32'h8000_0000) $display("[TB] FAIL reset_comb_out got %h want %h", out, 32'h8000_0000);
      else pass_count++;
      tick();
      ed = sb_data.pop_front(); eh = sb_hit.pop_front();
      check_count++;
      if (out_q !== ed || hit_q !== eh)
        $display("[TB] FAIL reset_regs got %h/%b want %h/%b", out_q, hit_q, ed, eh);
      else pass_count++;
      check_count++;
      if (e_out_q !== 1'b0 || e_hit_q !== 1'b0)
        $display("[TB] FAIL reset_edge_regs got %b/%b want 0/0", e_out_q, e_hit_q);
      else pass_count++;
    end
    drive(12'h305, CSR_LUT, 32'h0, 1'b1);
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    check_count++;
    if (out_q !== 32'h8000_0000 || hit_q !== 1'b1 || ed !== 32'h8000_0000)
      $display("[TB] FAIL reset_release got %h/%b want %h/1", out_q, hit_q, 32'h8000_0000);
    else pass_count++;
  endtask

  task automatic test_lookup();
    logic [11:0] keys [2] = '{12'h305, 12'h342};
    logic [31:0] want [2] = '{32'h8000_0000, 32'h0000_000B};
    logic [31:0] ed;
    logic        eh;
    for (int n = 0; n < 2; n++) begin
      drive(keys[n], CSR_LUT, 32'h0, 1'b1);
      check_count++;
      if (out !== want[n] || hit !== 1'b1)
        $display("[TB] FAIL lookup_comb key %h got %h/%b want %h/1", keys[n], out, hit, want[n]);
      else pass_count++;
      tick();
      ed = sb_data.pop_front(); eh = sb_hit.pop_front();
      check_count++;
      if (out_q !== ed || hit_q !== eh)
        $display("[TB] FAIL lookup_reg key %h got %h/%b want %h/%b", keys[n], out_q, hit_q, ed, eh);
      else pass_count++;
    end
  endtask

  task automatic test_default();
    logic [31:0] ed;
    logic        eh;
    drive(12'h304, CSR_LUT, 32'h0, 1'b1);
    check_count++;
    if (out !== 32'h0 || hit !== 1'b0)
      $display("[TB] FAIL default_zero got %h/%b want 0/0", out, hit);
    else pass_count++;
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    drive(12'h304, CSR_LUT, 32'hDEAD_BEEF, 1'b1);
    check_count++;
    if (out !== 32'hDEAD_BEEF || hit !== 1'b0)
      $display("[TB] FAIL default_value got %h/%b want deadbeef/0", out, hit);
    else pass_count++;
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    check_count++;
    if (out_q !== ed || hit_q !== eh)
      $display("[TB] FAIL default_reg got %h/%b want %h/%b", out_q, hit_q, ed, eh);
    else pass_count++;
  endtask

  task automatic test_duplicate();
    logic [31:0] ed;
    logic        eh;
    drive(12'h341, DUP_LUT, 32'hFFFF_FFFF, 1'b1);
    check_count++;
    if (out !== 32'h1 || hit !== 1'b1)
      $display("[TB] FAIL duplicate_priority got %h/%b want 00000001/1", out, hit);
    else pass_count++;
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    check_count++;
    if (out_q !== ed || hit_q !== eh)
      $display("[TB] FAIL duplicate_reg got %h/%b want %h/%b", out_q, hit_q, ed, eh);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] seq [6] = '{12'h300, 12'h341, 12'h7FF, 12'h341, 12'h300, 12'h7FF};
    logic [31:0] want [6] = '{32'h1800, 32'h1234_5678, 32'h5555_AAAA,
                              32'h1234_5678, 32'h1800, 32'h5555_AAAA};
    logic        want_hit [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ed;
    logic        eh;
    for (int n = 0; n < 6; n++) begin
      drive(seq[n], CSR_LUT, 32'h5555_AAAA, 1'b1);
      check_count++;
      if (out !== want[n] || hit !== want_hit[n])
        $display("[TB] FAIL toggle_comb step %0d got %h/%b want %h/%b", n, out, hit, want[n], want_hit[n]);
      else pass_count++;
      if (n > 0) begin
        check_count++;
        if (out_q !== want[n-1] || hit_q !== want_hit[n-1])
          $display("[TB] FAIL toggle_lag step %0d got %h/%b want %h/%b", n, out_q, hit_q,
                   want[n-1], want_hit[n-1]);
        else pass_count++;
      end
      tick();
      ed = sb_data.pop_front(); eh = sb_hit.pop_front();
      check_count++;
      if (out_q !== ed || hit_q !== eh)
        $display("[TB] FAIL toggle_reg step %0d got %h/%b want %h/%b", n, out_q, hit_q, ed, eh);
      else pass_count++;
    end
  endtask

  task automatic test_edge_params();
    logic [1:0] luts [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    logic       keys [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       defs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       want [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       wh   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      e_lut = luts[n]; e_key = keys[n]; e_def = defs[n];
      #1;
      check_count++;
      if (e_out !== want[n] || e_hit !== wh[n])
        $display("[TB] FAIL edge_comb case %0d got %b/%b want %b/%b", n, e_out, e_hit, want[n], wh[n]);
      else pass_count++;
      tick();
      check_count++;
      if (e_out_q !== want[n] || e_hit_q !== wh[n])
        $display("[TB] FAIL edge_reg case %0d got %b/%b want %b/%b", n, e_out_q, e_hit_q, want[n], wh[n]);
      else pass_count++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed;
    logic        eh;
    drive(12'h341, CSR_LUT, 32'h0, 1'b1);
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    drive(12'h341, CSR_LUT, 32'h0, 1'b0);
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    check_count++;
    if (out_q !== ed || hit_q !== eh || out !== 32'h1234_5678 || hit !== 1'b1)
      $display("[TB] FAIL reset_mid got q %h/%b comb %h/%b want q %h/%b comb 12345678/1",
               out_q, hit_q, out, hit, ed, eh);
    else pass_count++;
    drive(12'h341, CSR_LUT, 32'h0, 1'b1);
    tick();
    ed = sb_data.pop_front(); eh = sb_hit.pop_front();
    check_count++;
    if (out_q !== ed || hit_q !== eh)
      $display("[TB] FAIL reset_mid_release got %h/%b want %h/%b", out_q, hit_q, ed, eh);
    else pass_count++;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst = 1'b0; key = '0; default_out = '0; lut = '0;
    e_key = 1'b0; e_def = 1'b0; e_lut = 2'b00;
    test_reset();
    test_lookup();
    test_default();
    test_duplicate();
    test_back_to_back();
    test_reset_mid();
    test_edge_params();
    check_count++;
    if (sb_data.size() != 0)
      $display("[TB] FAIL scoreboard_drain got %0d left want 0", sb_data.size());
    else pass_count++;
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
